// File: rtl/jtframe_prog_pack.sv
// jtframe_prog_pack
// Packs the 8-bit ROM download stream into 16-bit SDRAM programming writes.
// Byte addresses are split into an SDRAM bank and an in-bank word address
// using configurable boundaries. Writes wait in a small FIFO so that SDRAM
// refresh or bank contention never stalls the loader.
module jtframe_prog_pack #(
  parameter int          SDRAMW    = 22,
  parameter logic [25:0] BA1_START = 26'h100_0000,
  parameter logic [25:0] BA2_START = 26'h200_0000,
  parameter logic [25:0] BA3_START = 26'h300_0000,
  parameter int          DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ioctl_rom,
  input  logic [25:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic              ioctl_wr,
  output logic [SDRAMW-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic [1:0]        prog_mask,
  output logic [1:0]        prog_ba,
  output logic              prog_we,
  input  logic              prog_rdy,
  output logic              dwnld_busy,
  output logic              overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [1:0]        ba;
    logic [SDRAMW-1:0] addr;
    logic [15:0]       data;
    logic [1:0]        mask;
  } entry_t;

  // Bank decode of the incoming byte
  logic [1:0]        w_ba;
  logic [25:0]       w_off;
  logic [SDRAMW-1:0] w_waddr;
  logic              w_odd;

  // Hold register: one byte waiting for its partner
  logic              r_hvalid;
  logic [1:0]        r_hba;
  logic [SDRAMW-1:0] r_hwaddr;
  logic [7:0]        r_hbyte;
  logic              r_hodd;

  // Push request generation
  logic   w_byte;
  logic   w_pair;
  logic   w_push_req;
  logic   w_hold_load;
  logic   w_hold_clear;
  entry_t w_push_entry;
  entry_t w_partial;

  // FIFO
  entry_t          r_mem [DEPTH];
  logic [PW-1:0]   r_wptr;
  logic [PW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_pop;
  logic            w_room;
  logic            w_push;
  logic            w_stall;
  logic            w_drop;
  entry_t          w_head;

  // Status
  logic r_rom_d;
  logic r_overflow;
  logic r_busy;

  // Map the byte address to a bank and an in-bank word address
  always_comb begin
    w_ba  = 2'd0;
    w_off = ioctl_addr;
    if (ioctl_addr >= BA3_START) begin
      w_ba  = 2'd3;
      w_off = ioctl_addr - BA3_START;
    end else if (ioctl_addr >= BA2_START) begin
      w_ba  = 2'd2;
      w_off = ioctl_addr - BA2_START;
    end else if (ioctl_addr >= BA1_START) begin
      w_ba  = 2'd1;
      w_off = ioctl_addr - BA1_START;
    end
    w_waddr = SDRAMW'(w_off >> 1);
    w_odd   = w_off[0];
  end

  assign w_byte = ioctl_rom & ioctl_wr;
  assign w_pair = r_hvalid & ~r_hodd & w_odd &
                  (r_hba == w_ba) & (r_hwaddr == w_waddr);

  // Decide what, if anything, goes into the FIFO this cycle
  always_comb begin
    w_partial.ba   = r_hba;
    w_partial.addr = r_hwaddr;
    w_partial.data = {r_hbyte, r_hbyte};
    w_partial.mask = r_hodd ? 2'b01 : 2'b10;

    w_push_req   = 1'b0;
    w_hold_load  = 1'b0;
    w_hold_clear = 1'b0;
    w_push_entry = '0;

    if (w_byte) begin
      if (w_pair) begin
        w_push_req        = 1'b1;
        w_push_entry.ba   = r_hba;
        w_push_entry.addr = r_hwaddr;
        w_push_entry.data = {ioctl_dout, r_hbyte};
        w_push_entry.mask = 2'b00;
        w_hold_clear      = 1'b1;
      end else if (r_hvalid) begin
        w_push_req   = 1'b1;
        w_push_entry = w_partial;
        w_hold_load  = 1'b1;
      end else begin
        w_hold_load = 1'b1;
      end
    end else if (!ioctl_rom && r_hvalid) begin
      w_push_req   = 1'b1;
      w_push_entry = w_partial;
      w_hold_clear = 1'b1;
    end
  end

  // A full FIFO still takes a push when the head leaves on the same edge.
  // A blocked end-of-download flush is not a lost byte: hold simply retries.
  assign w_pop   = prog_rdy & (r_count != '0);
  assign w_room  = (r_count < CW'(DEPTH)) | w_pop;
  assign w_push  = w_push_req & w_room;
  assign w_stall = w_push_req & ~w_room;
  assign w_drop  = w_stall & w_byte;

  // Hold register update; left untouched when the push it needs is blocked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hvalid <= 1'b0;
      r_hba    <= '0;
      r_hwaddr <= '0;
      r_hbyte  <= '0;
      r_hodd   <= 1'b0;
    end else if (!w_stall) begin
      if (w_hold_load) begin
        r_hvalid <= 1'b1;
        r_hba    <= w_ba;
        r_hwaddr <= w_waddr;
        r_hbyte  <= ioctl_dout;
        r_hodd   <= w_odd;
      end else if (w_hold_clear) begin
        r_hvalid <= 1'b0;
      end
    end
  end

  // FIFO storage; contents are only observed while the count is non-zero
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_push_entry;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head of the FIFO drives the programming port; idle values when empty
  assign w_head    = r_mem[r_rptr];
  assign prog_we   = (r_count != '0);
  assign prog_addr = prog_we ? w_head.addr : '0;
  assign prog_data = prog_we ? w_head.data : '0;
  assign prog_mask = prog_we ? w_head.mask : 2'b11;
  assign prog_ba   = prog_we ? w_head.ba   : 2'b00;

  // Sticky overflow, cleared when a new download starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rom_d    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_rom_d <= ioctl_rom;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ioctl_rom && !r_rom_d) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Busy while downloading or while anything is still waiting to be written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= ioctl_rom | r_hvalid | (r_count != '0);
    end
  end

  assign overflow   = r_overflow;
  assign dwnld_busy = r_busy;

endmodule

// File: tb/tb_jtframe_prog_pack.sv
// Testbench for jtframe_prog_pack: expected SDRAM writes are queued as the
// stimulus is issued; a monitor compares each write as it is acknowledged.
module tb_jtframe_prog_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ioctl_rom = 1'b0;
  logic [25:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wr = 1'b0;
  logic        prog_rdy = 1'b0;
  logic [21:0] prog_addr;
  logic [15:0] prog_data;
  logic [1:0]  prog_mask;
  logic [1:0]  prog_ba;
  logic        prog_we;
  logic        dwnld_busy;
  logic        overflow;

  typedef struct packed {
    logic [1:0]  ba;
    logic [21:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_got;
  exp_t mon_want;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  jtframe_prog_pack #(
    .SDRAMW   (22),
    .BA1_START(26'h100_0000),
    .BA2_START(26'h200_0000),
    .BA3_START(26'h300_0000),
    .DEPTH    (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ioctl_rom (ioctl_rom),
    .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout),
    .ioctl_wr  (ioctl_wr),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .prog_mask (prog_mask),
    .prog_ba   (prog_ba),
    .prog_we   (prog_we),
    .prog_rdy  (prog_rdy),
    .dwnld_busy(dwnld_busy),
    .overflow  (overflow)
  );

  function automatic exp_t mk(input logic [1:0] ba, input logic [21:0] addr,
                              input logic [15:0] data, input logic [1:0] mask);
    exp_t e;
    e.ba   = ba;
    e.addr = addr;
    e.data = data;
    e.mask = mask;
    return e;
  endfunction

  // Scoreboard monitor: sample on the falling edge, away from the active edge
  always @(negedge clk) begin
    if (rst_n && prog_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write got ba=%0d addr=%h data=%h mask=%b required no write",
                 prog_ba, prog_addr, prog_data, prog_mask);
      end else if (prog_rdy) begin
        mon_want = exp_q.pop_front();
        mon_got  = mk(prog_ba, prog_addr, prog_data, prog_mask);
        checks++;
        if (mon_got !== mon_want) begin
          errors++;
          $display("FAIL write got ba=%0d addr=%h data=%h mask=%b required ba=%0d addr=%h data=%h mask=%b",
                   mon_got.ba, mon_got.addr, mon_got.data, mon_got.mask,
                   mon_want.ba, mon_want.addr, mon_want.data, mon_want.mask);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %h required %h", name, act, req);
    end
  endtask

  task automatic send(input logic [25:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  // Acknowledge queued writes, each on the third cycle it has been presented
  task automatic drain(input int budget);
    int n;
    int w;
    n = 0;
    w = 0;
    while ((prog_we || exp_q.size() != 0) && n < budget) begin
      if (prog_we) w++;
      else w = 0;
      prog_rdy = (w >= 3);
      if (w >= 3) w = 0;
      tick();
      prog_rdy = 1'b0;
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending writes required 0", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lo;

    // Reset values
    #3;
    chk("rst_we", prog_we, 0);
    chk("rst_addr", prog_addr, 0);
    chk("rst_data", prog_data, 0);
    chk("rst_mask", prog_mask, 2'b11);
    chk("rst_ba", prog_ba, 0);
    chk("rst_busy", dwnld_busy, 0);
    chk("rst_ovf", overflow, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Even/odd pair forms one full word
    ioctl_rom = 1'b1;
    tick();
    exp_q.push_back(mk(2'd0, 22'h0, 16'h2211, 2'b00));
    send(26'h0, 8'h11);
    chk("t1_we_after_even", prog_we, 0);
    send(26'h1, 8'h22);
    chk("t1_we_rise", prog_we, 1);
    chk("t1_busy", dwnld_busy, 1);
    ioctl_rom = 1'b0;
    drain(100);
    chk("t1_busy_hold", dwnld_busy, 1);
    tick();
    chk("t1_busy_fall", dwnld_busy, 0);

    // Lone odd byte in bank 1 flushed at end of download
    ioctl_rom = 1'b1;
    tick();
    exp_q.push_back(mk(2'd1, 22'h2, 16'hABAB, 2'b01));
    send(26'h100_0005, 8'hAB);
    chk("t2_no_push_while_rom", prog_we, 0);
    ioctl_rom = 1'b0;
    drain(100);

    // Two even bytes become two ordered partial writes
    ioctl_rom = 1'b1;
    tick();
    exp_q.push_back(mk(2'd0, 22'h8, 16'h3333, 2'b10));
    exp_q.push_back(mk(2'd0, 22'h9, 16'h4444, 2'b10));
    send(26'h10, 8'h33);
    send(26'h12, 8'h44);
    chk("t3_first_partial", prog_we, 1);
    ioctl_rom = 1'b0;
    drain(100);

    // Overflow: 4 words queue, later bytes dropped, byte 8 stays in hold
    ioctl_rom = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      lo = 8'hA0 + 8'(2 * i);
      exp_q.push_back(mk(2'd0, 22'h10 + 22'(i), {lo + 8'h1, lo}, 2'b00));
    end
    exp_q.push_back(mk(2'd0, 22'h14, 16'hA8A8, 2'b10));
    for (int i = 0; i < 12; i++) begin
      send(26'h20 + 26'(i), 8'hA0 + 8'(i));
    end
    chk("t4_ovf_set", overflow, 1);
    ioctl_rom = 1'b0;
    drain(200);
    chk("t4_ovf_sticky", overflow, 1);

    // Full FIFO with simultaneous pop and completing push
    ioctl_rom = 1'b1;
    tick();
    chk("t5_ovf_clear_on_rise", overflow, 0);
    for (int i = 0; i < 5; i++) begin
      lo = 8'h40 + 8'(2 * i);
      exp_q.push_back(mk(2'd0, 22'h80 + 22'(i), {lo + 8'h1, lo}, 2'b00));
    end
    for (int i = 0; i < 9; i++) begin
      send(26'h100 + 26'(i), 8'h40 + 8'(i));
    end
    prog_rdy = 1'b1;
    send(26'h109, 8'h49);
    prog_rdy = 1'b0;
    chk("t5_ovf_stays_clear", overflow, 0);
    chk("t5_we", prog_we, 1);
    ioctl_rom = 1'b0;
    drain(200);

    // Reset with three entries queued
    ioctl_rom = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      lo = 8'h60 + 8'(2 * i);
      exp_q.push_back(mk(2'd0, 22'h200 + 22'(i), {lo + 8'h1, lo}, 2'b00));
    end
    for (int i = 0; i < 6; i++) begin
      send(26'h400 + 26'(i), 8'h60 + 8'(i));
    end
    chk("t6_we_before_rst", prog_we, 1);
    #2;
    rst_n     = 1'b0;
    ioctl_rom = 1'b0;
    #1;
    chk("t6_we_async", prog_we, 0);
    chk("t6_mask_async", prog_mask, 2'b11);
    chk("t6_busy_async", dwnld_busy, 0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      prog_rdy = ~prog_rdy;
      tick();
    end
    prog_rdy = 1'b0;
    chk("t6_no_stale", prog_we, 0);
    chk("end_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
